// File: rtl/aes64_pkg.sv
// aes64_pkg: shared constants and helper functions for the 64-bit
// lightweight cipher. Holds the 4-bit S-box and its inverse, the round
// count, the rotate amounts, and the nibble-substitution, rotate and
// round-key functions used by aes64_cipher_core.
package aes64_pkg;

  localparam int ROUNDS    = 4;
  localparam int KEY_ROT   = 13;
  localparam int STATE_ROT = 8;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  // A shift by 64 or more would be out of range, so reduce first and
  // treat a zero rotate as the identity.
  function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned n);
    int unsigned m;
    m = n % 64;
    if (m == 0) return x;
    return (x << m) | (x >> (64 - m));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    int unsigned m;
    m = n % 64;
    if (m == 0) return x;
    return (x >> m) | (x << (64 - m));
  endfunction

  function automatic logic [63:0] sub_nibbles(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 16; j++) y[4*j +: 4] = SBOX[x[4*j +: 4]];
    return y;
  endfunction

  function automatic logic [63:0] inv_sub_nibbles(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 16; j++) y[4*j +: 4] = INV_SBOX[x[4*j +: 4]];
    return y;
  endfunction

  function automatic logic [63:0] round_key(input logic [63:0] key, input int unsigned i);
    return rotl64(key, KEY_ROT * i) ^ 64'(i);
  endfunction

endpackage

// File: rtl/aes64_cipher_core.sv
// aes64_cipher_core: purely combinational encrypt and decrypt of one
// 64-bit block under a 64-bit key.
//   data_in [63:0] block to transform
//   key     [63:0] cipher key
//   enc_out [63:0] E(data_in, key)
//   dec_out [63:0] D(data_in, key)
module aes64_cipher_core
  import aes64_pkg::*;
(
  input  logic [63:0] data_in,
  input  logic [63:0] key,
  output logic [63:0] enc_out,
  output logic [63:0] dec_out
);

  logic [63:0] enc_s;
  logic [63:0] dec_s;

  always_comb begin
    enc_s = data_in;
    for (int i = 0; i < ROUNDS; i++)
      enc_s = rotl64(sub_nibbles(enc_s ^ round_key(key, i)), STATE_ROT);
    enc_out = enc_s ^ round_key(key, ROUNDS);
  end

  // Undo the rounds in reverse order: unrotate, inverse S-box, then key.
  always_comb begin
    dec_s = data_in ^ round_key(key, ROUNDS);
    for (int i = ROUNDS - 1; i >= 0; i--)
      dec_s = inv_sub_nibbles(rotr64(dec_s, STATE_ROT)) ^ round_key(key, i);
    dec_out = dec_s;
  end

endmodule

// File: rtl/aes64_crypt_fifo.sv
// aes64_crypt_fifo: secure buffer. Writes are encrypted and pushed into
// a ciphertext FIFO; reads pop the oldest entry and decrypt it with the
// key presented at read time.
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   data  [63:0] plaintext input
//   key   [63:0] cipher key for both directions (not stored)
//   we           write strobe: encrypt and push
//   re           read strobe: pop and decrypt
//   encrypt_data registered ciphertext of the last write strobe
//   decrypt_data registered plaintext of the last successful read
//   full / empty FIFO occupancy flags
module aes64_crypt_fifo
  import aes64_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] data,
  input  logic [63:0] key,
  input  logic        we,
  input  logic        re,
  output logic [63:0] encrypt_data,
  output logic [63:0] decrypt_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("aes64_crypt_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic [63:0]   enc_q,    enc_d;
  logic [63:0]   dec_q,    dec_d;

  logic [63:0] wr_cipher, rd_plain;
  logic [63:0] wr_dec_unused, rd_enc_unused;
  logic        do_wr, do_rd;

  aes64_cipher_core u_wr_core (
    .data_in (data),
    .key     (key),
    .enc_out (wr_cipher),
    .dec_out (wr_dec_unused)
  );

  aes64_cipher_core u_rd_core (
    .data_in (mem_q[rd_ptr_q]),
    .key     (key),
    .enc_out (rd_enc_unused),
    .dec_out (rd_plain)
  );

  // Flags come from the pre-edge count, so a full FIFO still pops and
  // an empty FIFO never bypasses the incoming write to the read side.
  assign do_wr = we && (count_q != FULL_CNT);
  assign do_rd = re && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    enc_d    = enc_q;
    dec_d    = dec_q;
    if (we)    enc_d    = wr_cipher;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) begin
      dec_d    = rd_plain;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_wr && !do_rd)      count_d = count_q + 1'b1;
    else if (do_rd && !do_wr) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      enc_q    <= '0;
      dec_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      enc_q    <= enc_d;
      dec_q    <= dec_d;
    end
  end

  // Storage is deliberately not reset; stale entries are unreachable
  // once the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_cipher;
  end

  assign encrypt_data = enc_q;
  assign decrypt_data = dec_q;
  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);

endmodule

// File: tb/tb_aes64_crypt_fifo.sv
module tb_aes64_crypt_fifo;

  localparam int DEPTH = 16;

  localparam bit [3:0] TS [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };
  localparam bit [3:0] TSI [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] data = '0;
  logic [63:0] key = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [63:0] encrypt_data, decrypt_data;
  logic        full, empty;

  aes64_crypt_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .data         (data),
    .key          (key),
    .we           (we),
    .re           (re),
    .encrypt_data (encrypt_data),
    .decrypt_data (decrypt_data),
    .full         (full),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] v;
    logic [63:0] plain;
    bit          ne;
  } exp_t;

  typedef struct {
    logic [63:0] c;
    logic [63:0] p;
    logic [63:0] k;
  } ent_t;

  exp_t enc_q[$];
  exp_t dec_q[$];
  ent_t m_fifo[$];
  logic [63:0] last_dec = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_ne(input string nm, input logic [63:0] act, input logic [63:0] notv);
    total++;
    if (act === notv) begin
      bad++;
      $display("FAIL %s: got %h must differ from %h", nm, act, notv);
    end
  endtask

  // Reference cipher, written nibble-by-nibble from the cipher definition.
  function automatic logic [63:0] t_rotl(logic [63:0] x, int n);
    logic [63:0] y;
    y = x;
    for (int i = 0; i < n % 64; i++) y = {y[62:0], y[63]};
    return y;
  endfunction

  function automatic logic [63:0] t_rk(logic [63:0] k, int i);
    return t_rotl(k, 13 * i) ^ 64'(i);
  endfunction

  function automatic logic [63:0] t_enc(logic [63:0] d, logic [63:0] k);
    logic [63:0] s, u;
    s = d;
    for (int r = 0; r < 4; r++) begin
      s = s ^ t_rk(k, r);
      u = '0;
      for (int j = 0; j < 16; j++) u[4*j +: 4] = TS[s[4*j +: 4]];
      s = t_rotl(u, 8);
    end
    return s ^ t_rk(k, 4);
  endfunction

  function automatic logic [63:0] t_dec(logic [63:0] c, logic [63:0] k);
    logic [63:0] s, u;
    s = c ^ t_rk(k, 4);
    for (int r = 3; r >= 0; r--) begin
      s = t_rotl(s, 56);
      u = '0;
      for (int j = 0; j < 16; j++) u[4*j +: 4] = TSI[s[4*j +: 4]];
      s = u ^ t_rk(k, r);
    end
    return s;
  endfunction

  // One strobe cycle; expectations go to the scoreboard queues.
  task automatic cyc(input bit w, input bit r, input logic [63:0] d, input bit ne_chk);
    int   sz;
    ent_t e;
    exp_t x;
    @(negedge clk);
    we = w; re = r; data = d;
    sz = m_fifo.size();
    if (r) begin
      if (sz > 0) begin
        e = m_fifo.pop_front();
        last_dec = (e.k == key) ? e.p : t_dec(e.c, key);
      end
      x.v = last_dec; x.plain = '0; x.ne = 1'b0;
      dec_q.push_back(x);
    end
    if (w) begin
      e.c = t_enc(d, key); e.p = d; e.k = key;
      x.v = e.c; x.plain = d; x.ne = ne_chk;
      enc_q.push_back(x);
      if (sz < DEPTH) m_fifo.push_back(e);
    end
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic chk_flags(input string nm);
    @(negedge clk);
    check({nm, "_full"},  64'(full),  64'(m_fifo.size() == DEPTH));
    check({nm, "_empty"}, 64'(empty), 64'(m_fifo.size() == 0));
  endtask

  // Monitor: every strobe seen at a rising edge produces one output to
  // compare on the following falling edge.
  always begin
    bit   w_s, r_s;
    exp_t x;
    @(posedge clk);
    w_s = we; r_s = re;
    @(negedge clk);
    if (w_s) begin
      if (enc_q.size() == 0) begin
        total++; bad++;
        $display("FAIL enc_scoreboard: got output %h want no pending entry", encrypt_data);
      end else begin
        x = enc_q.pop_front();
        check("encrypt_data", encrypt_data, x.v);
        if (x.ne) check_ne("enc_vs_plain", encrypt_data, x.plain);
      end
    end
    if (r_s) begin
      if (dec_q.size() == 0) begin
        total++; bad++;
        $display("FAIL dec_scoreboard: got output %h want no pending entry", decrypt_data);
      end else begin
        x = dec_q.pop_front();
        check("decrypt_data", decrypt_data, x.v);
      end
    end
  end

  initial begin
    logic [63:0] pk [10];
    logic [63:0] k1, k2, p;

    #2;
    check("rst_enc", encrypt_data, 64'h0);
    check("rst_dec", decrypt_data, 64'h0);
    check("rst_empty", 64'(empty), 64'h1);
    check("rst_full", 64'(full), 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // Hand-computed vector: key=0, data=0.
    key = '0;
    cyc(1, 0, 64'h0, 0);
    @(negedge clk);
    check("kat_zero_enc", encrypt_data, 64'hEEEEEEEEE7EFEFEA);
    cyc(0, 1, 64'h0, 0);
    @(negedge clk);
    check("kat_zero_dec", decrypt_data, 64'h0);
    check("kat_zero_empty", 64'(empty), 64'h1);

    // Random key, 10 packets in, idle, 10 out in order.
    void'($urandom(32'd20240611));
    key = {$urandom, $urandom};
    for (int i = 0; i < 10; i++) begin
      pk[i] = {$urandom, $urandom};
      cyc(1, 0, pk[i], 1);
    end
    repeat (5) @(negedge clk);
    for (int i = 0; i < 10; i++) cyc(0, 1, 64'h0, 0);
    chk_flags("rand_done");

    // Fill past capacity: the extra push is dropped.
    key = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 64'h1000 + 64'(i), 1);
    chk_flags("fill");
    check("fill_full_hard", 64'(full), 64'h1);
    cyc(1, 0, 64'hDEAD_BEEF_0000_0001, 0);
    chk_flags("overflow");
    // Full FIFO with we+re: read succeeds, write is dropped.
    cyc(1, 1, 64'hDEAD_BEEF_0000_0002, 0);
    chk_flags("full_rw");
    for (int i = 1; i < DEPTH; i++) cyc(0, 1, 64'h0, 0);
    chk_flags("drain");
    check("drain_empty_hard", 64'(empty), 64'h1);

    // Reads on empty hold decrypt_data; we+re on empty only writes.
    p = decrypt_data;
    cyc(0, 1, 64'h0, 0);
    @(negedge clk);
    check("empty_read_hold", decrypt_data, p);
    cyc(1, 1, 64'h5555_AAAA_5555_AAAA, 1);
    chk_flags("empty_rw");
    check("empty_rw_dec_hold", decrypt_data, p);
    cyc(0, 1, 64'h0, 0);
    chk_flags("empty_rw_drain");

    // Asynchronous reset mid-stream.
    key = 64'hFEDC_BA98_7654_3210;
    for (int i = 0; i < 3; i++) cyc(1, 0, 64'h7700 + 64'(i), 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_enc", encrypt_data, 64'h0);
    check("async_rst_dec", decrypt_data, 64'h0);
    check("async_rst_empty", 64'(empty), 64'h1);
    m_fifo.delete();
    last_dec = '0;
    @(negedge clk);
    rst = 1'b1;
    cyc(1, 0, 64'hCAFE_F00D_1234_5678, 1);
    cyc(0, 1, 64'h0, 0);
    chk_flags("post_rst");

    // Key change between write and read.
    k1 = 64'h1111_2222_3333_4444;
    k2 = 64'h9999_8888_7777_6666;
    p  = 64'h0BAD_CAFE_600D_F00D;
    key = k1;
    cyc(1, 0, p, 1);
    cyc(1, 0, p, 1);
    key = k2;
    cyc(0, 1, 64'h0, 0);
    @(negedge clk);
    check_ne("wrong_key_dec", decrypt_data, p);
    key = k1;
    cyc(0, 1, 64'h0, 0);
    @(negedge clk);
    check("right_key_dec", decrypt_data, p);

    repeat (3) @(negedge clk);
    check("enc_q_drained", 64'(enc_q.size()), 64'h0);
    check("dec_q_drained", 64'(dec_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
